rv_multicycle_ctrl: RTL and testbench

Parametrised multi-cycle RV32I/RV64I control unit: the successor to the current fixed-width decode/control FSM.
- Latches the fetched instruction and generates XLEN-wide immediates for all formats.
- Sequences FETCH/DECODE/EXEC/MEM/WB with a memory ready handshake.
- Drives datapath mux selects, write enables and ALU control; traps on illegal opcodes.
- Sits between the unified instruction/data memory port and the ALU/register-file datapath.

---
 rtl/rv_multicycle_ctrl_if.sv | 38 +++
 rtl/rv_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rv_multicycle_ctrl_if.sv
// rtl/rv_multicycle_ctrl_if.sv - memory handshake and datapath control bundle for rv_multicycle_ctrl
interface rv_multicycle_ctrl_if #(
  parameter int XLEN     = 32,
  parameter int ALUCTL_W = 4
);
  logic [31:0]         instr;
  logic                mem_ready;
  logic                cond_true;
  logic [2:0]          state;
  logic                ir_write;
  logic                mem_req;
  logic                iord;
  logic                mem_write;
  logic                reg_write;
  logic [1:0]          wb_sel;
  logic                pc_write;
  logic [1:0]          pc_sel;
  logic [1:0]          alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUCTL_W-1:0] alu_ctl;
  logic [XLEN-1:0]     imm;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [4:0]          rd;
  logic                illegal;

  modport master (
    input  instr, mem_ready, cond_true,
    output state, ir_write, mem_req, iord, mem_write, reg_write, wb_sel,
           pc_write, pc_sel, alu_src_a, alu_src_b, alu_ctl, imm, rs1, rs2, rd, illegal
  );

  modport slave (
    output instr, mem_ready, cond_true,
    input  state, ir_write, mem_req, iord, mem_write, reg_write, wb_sel,
           pc_write, pc_sel, alu_src_a, alu_src_b, alu_ctl, imm, rs1, rs2, rd, illegal
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - multi-cycle RV32I/RV64I decode and control FSM
module rv_multicycle_ctrl #(
  parameter int XLEN        = 32,
  parameter int ALUCTL_W    = 4,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic clk,
  input  logic reset,
  rv_multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  state_t          state_q, state_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            f7b5_q, f7b5_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic            taken_q, taken_d;

  logic            rdy;
  logic [6:0]      f_op;
  logic [31:0]     imm32;
  logic            is_shamt;
  logic [XLEN-1:0] imm_new;

  logic is_r, is_opimm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, legal;

  assign rdy  = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;
  assign f_op = bus.instr[6:0];

  assign is_r      = (opcode_q == OP_REG);
  assign is_opimm  = (opcode_q == OP_IMM);
  assign is_load   = (opcode_q == OP_LOAD);
  assign is_store  = (opcode_q == OP_STORE);
  assign is_branch = (opcode_q == OP_BRANCH);
  assign is_jal    = (opcode_q == OP_JAL);
  assign is_jalr   = (opcode_q == OP_JALR);
  assign is_lui    = (opcode_q == OP_LUI);
  assign is_auipc  = (opcode_q == OP_AUIPC);
  assign legal     = is_r | is_opimm | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;

  // Immediate is built from the raw fetch data so it is ready on the DECODE cycle.
  always_comb begin
    imm32    = 32'd0;
    is_shamt = 1'b0;
    case (f_op)
      OP_IMM: begin
        is_shamt = (bus.instr[13:12] == 2'b01);
        imm32    = {{20{bus.instr[31]}}, bus.instr[31:20]};
      end
      OP_LOAD, OP_JALR: imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
      OP_STORE:         imm32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      OP_BRANCH:        imm32 = {{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25],
                                 bus.instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {bus.instr[31:12], 12'd0};
      OP_JAL:           imm32 = {{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20],
                                 bus.instr[30:21], 1'b0};
      default:          imm32 = 32'd0;
    endcase
    if (is_shamt) begin
      if (XLEN == 64) imm_new = XLEN'(bus.instr[25:20]);
      else            imm_new = XLEN'(bus.instr[24:20]);
    end else begin
      imm_new = XLEN'($signed(imm32));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      opcode_q <= 7'd0;
      funct3_q <= 3'd0;
      f7b5_q   <= 1'b0;
      rd_q     <= 5'd0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      imm_q    <= '0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct3_q <= funct3_d;
      f7b5_q   <= f7b5_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      taken_q  <= taken_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    funct3_d = funct3_q;
    f7b5_d   = f7b5_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    taken_d  = taken_q;
    case (state_q)
      ST_FETCH: begin
        if (rdy) begin
          opcode_d = f_op;
          funct3_d = bus.instr[14:12];
          f7b5_d   = bus.instr[30];
          rd_d     = bus.instr[11:7];
          rs1_d    = bus.instr[19:15];
          rs2_d    = bus.instr[24:20];
          imm_d    = imm_new;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!legal)      state_d = ST_TRAP;
        else if (is_lui) state_d = ST_WB;
        else             state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_branch) taken_d = bus.cond_true;
        state_d = (is_load || is_store) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (rdy) state_d = is_store ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  logic                ir_write, mem_req, iord, mem_write, reg_write, pc_write;
  logic [1:0]          wb_sel, pc_sel, alu_src_a, alu_src_b;
  logic [ALUCTL_W-1:0] alu_ctl;

  always_comb begin
    ir_write  = 1'b0;
    mem_req   = 1'b0;
    iord      = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    wb_sel    = 2'b00;
    pc_sel    = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_ctl   = '0;
    case (state_q)
      ST_FETCH: begin
        mem_req  = 1'b1;
        ir_write = rdy;
      end
      ST_EXEC: begin
        if (is_r) begin
          alu_src_a = 2'b01;
          alu_ctl   = ALUCTL_W'({f7b5_q, funct3_q});
        end else if (is_opimm) begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          alu_ctl   = ALUCTL_W'({f7b5_q & (funct3_q == 3'b101), funct3_q});
        end else if (is_load || is_store || is_jalr) begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end else begin
          alu_src_b = 2'b10;
        end
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = is_store;
        pc_write  = is_store & rdy;
      end
      ST_WB: begin
        pc_write  = 1'b1;
        reg_write = (is_r | is_opimm | is_load | is_jal | is_jalr | is_lui | is_auipc) &&
                    (rd_q != 5'd0);
        if (is_load)              wb_sel = 2'b01;
        else if (is_jal||is_jalr) wb_sel = 2'b10;
        else if (is_lui)          wb_sel = 2'b11;
        if (is_jal || (is_branch && taken_q)) pc_sel = 2'b01;
        else if (is_jalr)                     pc_sel = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.state     = state_q;
  assign bus.ir_write  = ir_write;
  assign bus.mem_req   = mem_req;
  assign bus.iord      = iord;
  assign bus.mem_write = mem_write;
  assign bus.reg_write = reg_write;
  assign bus.wb_sel    = wb_sel;
  assign bus.pc_write  = pc_write;
  assign bus.pc_sel    = pc_sel;
  assign bus.alu_src_a = alu_src_a;
  assign bus.alu_src_b = alu_src_b;
  assign bus.alu_ctl   = alu_ctl;
  assign bus.imm       = imm_q;
  assign bus.rs1       = rs1_q;
  assign bus.rs2       = rs2_q;
  assign bus.rd        = rd_q;
  assign bus.illegal   = (state_q == ST_TRAP);
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb/tb_rv_multicycle_ctrl.sv - table-driven bench for rv_multicycle_ctrl
module tb_rv_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv_multicycle_ctrl_if #(.XLEN(32), .ALUCTL_W(4)) bus ();

  rv_multicycle_ctrl #(.XLEN(32), .ALUCTL_W(4), .MEM_WAIT_EN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic        mr;
    logic        ct;
    logic [2:0]  st;
    logic [17:0] ctl;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passes = 0;

  function automatic logic [17:0] mk(input logic ir, input logic rq, input logic io,
                                     input logic mw, input logic rw, input logic [1:0] wb,
                                     input logic pw, input logic [1:0] ps, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [3:0] ac);
    return {ir, rq, io, mw, rw, wb, pw, ps, sa, sb, ac};
  endfunction

  function automatic logic [17:0] dut_ctl();
    return {bus.ir_write, bus.mem_req, bus.iord, bus.mem_write, bus.reg_write, bus.wb_sel,
            bus.pc_write, bus.pc_sel, bus.alu_src_a, bus.alu_src_b, bus.alu_ctl};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic [31:0] i, input logic mr, input logic ct, input logic [2:0] st,
                     input logic [17:0] ctl, input logic [31:0] imm);
    vec_t v;
    v.instr = i; v.mr = mr; v.ct = ct; v.st = st; v.ctl = ctl; v.imm = imm;
    vecs.push_back(v);
  endtask

  initial begin
    logic [17:0] f1, f0, z, ei, ep, wba, ml, ms;
    logic [31:0] a_i, s_i, r_i, l_i, w_i, n_i, u_i, b_i, j_i, x_i;
    f1  = mk(1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 4'd0);
    f0  = mk(0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 4'd0);
    z   = 18'd0;
    ei  = mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd1, 2'd2, 4'd0);
    ep  = mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd2, 4'd0);
    wba = mk(0, 0, 0, 0, 1, 2'd0, 1, 2'd0, 2'd0, 2'd0, 4'd0);
    ml  = mk(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 4'd0);
    ms  = mk(0, 1, 1, 1, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 4'd0);
    a_i = 32'h00500093; s_i = 32'h402081B3; r_i = 32'h4030D093; l_i = 32'h0040A103;
    w_i = 32'h0020A423; n_i = 32'h00100013; u_i = 32'h123452B7; b_i = 32'hFE000CE3;
    j_i = 32'h010000EF; x_i = 32'h0000007F;

    // addi x1,x0,5
    add(a_i, 1, 0, 0, f1, 32'd0);
    add(a_i, 1, 0, 1, z, 32'd5);
    add(a_i, 1, 0, 2, ei, 32'd5);
    add(a_i, 1, 0, 4, wba, 32'd5);
    // sub x3,x1,x2 with one FETCH wait
    add(s_i, 0, 0, 0, f0, 32'd5);
    add(s_i, 1, 0, 0, f1, 32'd5);
    add(s_i, 1, 0, 1, z, 32'd0);
    add(s_i, 1, 0, 2, mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd1, 2'd0, 4'b1000), 32'd0);
    add(s_i, 1, 0, 4, wba, 32'd0);
    // srai x1,x1,3
    add(r_i, 1, 0, 0, f1, 32'd0);
    add(r_i, 1, 0, 1, z, 32'd3);
    add(r_i, 1, 0, 2, mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd1, 2'd2, 4'b1101), 32'd3);
    add(r_i, 1, 0, 4, wba, 32'd3);
    // lw x2,4(x1) with two MEM waits
    add(l_i, 1, 0, 0, f1, 32'd3);
    add(l_i, 1, 0, 1, z, 32'd4);
    add(l_i, 1, 0, 2, ei, 32'd4);
    add(l_i, 0, 0, 3, ml, 32'd4);
    add(l_i, 0, 0, 3, ml, 32'd4);
    add(l_i, 1, 0, 3, ml, 32'd4);
    add(l_i, 1, 0, 4, mk(0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 2'd0, 2'd0, 4'd0), 32'd4);
    // sw x2,8(x1) with one MEM wait
    add(w_i, 1, 0, 0, f1, 32'd4);
    add(w_i, 1, 0, 1, z, 32'd8);
    add(w_i, 1, 0, 2, ei, 32'd8);
    add(w_i, 0, 0, 3, ms, 32'd8);
    add(w_i, 1, 0, 3, mk(0, 1, 1, 1, 0, 2'd0, 1, 2'd0, 2'd0, 2'd0, 4'd0), 32'd8);
    // addi x0,x0,1: write suppressed
    add(n_i, 1, 0, 0, f1, 32'd8);
    add(n_i, 1, 0, 1, z, 32'd1);
    add(n_i, 1, 0, 2, ei, 32'd1);
    add(n_i, 1, 0, 4, mk(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd0, 4'd0), 32'd1);
    // lui x5,0x12345
    add(u_i, 1, 0, 0, f1, 32'd1);
    add(u_i, 1, 0, 1, z, 32'h12345000);
    add(u_i, 1, 0, 4, mk(0, 0, 0, 0, 1, 2'd3, 1, 2'd0, 2'd0, 2'd0, 4'd0), 32'h12345000);
    // beq taken then not taken
    add(b_i, 1, 0, 0, f1, 32'h12345000);
    add(b_i, 1, 0, 1, z, 32'hFFFFFFF8);
    add(b_i, 1, 1, 2, ep, 32'hFFFFFFF8);
    add(b_i, 1, 0, 4, mk(0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 2'd0, 4'd0), 32'hFFFFFFF8);
    add(b_i, 1, 0, 0, f1, 32'hFFFFFFF8);
    add(b_i, 1, 1, 1, z, 32'hFFFFFFF8);
    add(b_i, 1, 0, 2, ep, 32'hFFFFFFF8);
    add(b_i, 1, 1, 4, mk(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd0, 4'd0), 32'hFFFFFFF8);
    // jal x1,+16
    add(j_i, 1, 0, 0, f1, 32'hFFFFFFF8);
    add(j_i, 1, 0, 1, z, 32'd16);
    add(j_i, 1, 0, 2, ep, 32'd16);
    add(j_i, 1, 0, 4, mk(0, 0, 0, 0, 1, 2'd2, 1, 2'd1, 2'd0, 2'd0, 4'd0), 32'd16);
    // illegal opcode traps and stays
    add(x_i, 1, 0, 0, f1, 32'd16);
    add(x_i, 1, 0, 1, z, 32'd0);
    add(x_i, 1, 0, 5, z, 32'd0);
    add(x_i, 1, 0, 5, z, 32'd0);
    add(x_i, 0, 1, 5, z, 32'd0);

    reset = 1'b1;
    bus.instr = 32'd0; bus.mem_ready = 1'b0; bus.cond_true = 1'b0;
    #1;
    chk("reset state", 64'(bus.state), 64'd0);
    chk("reset illegal", 64'(bus.illegal), 64'd0);
    chk("reset imm", 64'(bus.imm), 64'd0);
    chk("reset ctl", 64'(dut_ctl()), 64'(f0));
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.instr = vecs[i].instr; bus.mem_ready = vecs[i].mr; bus.cond_true = vecs[i].ct;
      #1;
      chk($sformatf("row%0d state", i), 64'(bus.state), 64'(vecs[i].st));
      chk($sformatf("row%0d ctl", i), 64'(dut_ctl()), 64'(vecs[i].ctl));
      chk($sformatf("row%0d imm", i), 64'(bus.imm), 64'(vecs[i].imm));
      chk($sformatf("row%0d illegal", i), 64'(bus.illegal), 64'(vecs[i].st == 3'd5));
      @(negedge clk);
    end
    chk("jal rd", 64'(bus.rd), 64'd0);

    // Asynchronous reset in the middle of a stalled store access
    reset = 1'b1; #1; reset = 1'b0;
    @(negedge clk);
    bus.instr = w_i; bus.mem_ready = 1'b1; bus.cond_true = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("store mem state", 64'(bus.state), 64'd3);
    chk("store mem_write", 64'(bus.mem_write), 64'd1);
    chk("store rs2", 64'(bus.rs2), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("async reset state", 64'(bus.state), 64'd0);
    chk("async reset mem_write", 64'(bus.mem_write), 64'd0);
    chk("async reset illegal", 64'(bus.illegal), 64'd0);
    chk("async reset imm", 64'(bus.imm), 64'd0);
    chk("async reset rd", 64'(bus.rd), 64'd0);
    @(negedge clk);
    reset = 1'b0; bus.mem_ready = 1'b1; bus.instr = a_i;
    #1;
    chk("post reset fetch ir_write", 64'(bus.ir_write), 64'd1);
    @(negedge clk);
    #1;
    chk("post reset decode", 64'(bus.state), 64'd1);
    chk("post reset rd", 64'(bus.rd), 64'd1);
    chk("post reset imm", 64'(bus.imm), 64'd5);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
